// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with MEM/WB operand forwarding and load-use detection.
// Define EX_FORWARD_EN to enable forwarding; without it, RAW hazards are resolved by stalling.
module ex_operand_stage #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic [WIDTH-1:0]      RD1D,
  input  logic [WIDTH-1:0]      RD2D,
  input  logic [WIDTH-1:0]      PCD,
  input  logic [WIDTH-1:0]      ImmExtD,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] RdD,
  input  logic [3:0]            ALUctrlD,
  input  logic                  ALUsrcAD,
  input  logic                  ALUsrcBD,
  input  logic                  RegWriteD,
  input  logic                  MemReadD,
  input  logic [ADDR_WIDTH-1:0] RdM,
  input  logic                  RegWriteM,
  input  logic [WIDTH-1:0]      ALUResultM,
  input  logic [ADDR_WIDTH-1:0] RdW,
  input  logic                  RegWriteW,
  input  logic [WIDTH-1:0]      ResultW,
  output logic [WIDTH-1:0]      SrcAE,
  output logic [WIDTH-1:0]      SrcBE,
  output logic [3:0]            ALUctrlE,
  output logic [WIDTH-1:0]      WriteDataE,
  output logic [ADDR_WIDTH-1:0] RdE,
  output logic                  RegWriteE,
  output logic                  MemReadE,
  output logic                  ValidE,
  output logic                  LoadUseStall
);
  logic [WIDTH-1:0]      rd1_q, rd2_q, pc_q, imm_q, fwd_a, fwd_b;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [3:0]            alu_ctrl_q;
  logic                  src_a_q, src_b_q, reg_write_q, mem_read_q, valid_q;
  logic                  rs1_hit_e, rs2_hit_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q       <= '0;
      rd2_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_ctrl_q  <= '0;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else if (FlushE) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rd_q        <= '0;
      alu_ctrl_q  <= '0;
    end else if (!StallE) begin
      rd1_q       <= RD1D;
      rd2_q       <= RD2D;
      pc_q        <= PCD;
      imm_q       <= ImmExtD;
      rs1_q       <= Rs1D;
      rs2_q       <= Rs2D;
      rd_q        <= RdD;
      alu_ctrl_q  <= ALUctrlD;
      src_a_q     <= ALUsrcAD;
      src_b_q     <= ALUsrcBD;
      reg_write_q <= RegWriteD;
      mem_read_q  <= MemReadD;
      valid_q     <= ValidD;
    end
  end

  assign rs1_hit_e = (rd_q != '0) && (rd_q == Rs1D);
  assign rs2_hit_e = (rd_q != '0) && (rd_q == Rs2D);

`ifdef EX_FORWARD_EN
  always_comb begin
    fwd_a = (RegWriteM && RdM != '0 && RdM == rs1_q) ? ALUResultM :
            (RegWriteW && RdW != '0 && RdW == rs1_q) ? ResultW : rd1_q;
    fwd_b = (RegWriteM && RdM != '0 && RdM == rs2_q) ? ALUResultM :
            (RegWriteW && RdW != '0 && RdW == rs2_q) ? ResultW : rd2_q;
  end
  assign LoadUseStall = valid_q & mem_read_q & (rs1_hit_e | rs2_hit_e);
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_q, rs2_q, ALUResultM, RdW, RegWriteW, ResultW};
  assign fwd_a = rd1_q;
  assign fwd_b = rd2_q;
  // Without forwarding, any in-flight producer in E or M must hold the consumer in D.
  assign LoadUseStall = (valid_q & reg_write_q & (rs1_hit_e | rs2_hit_e)) |
                        (RegWriteM & (RdM != '0) & ((RdM == Rs1D) | (RdM == Rs2D)));
`endif

  assign SrcAE      = src_a_q ? pc_q : fwd_a;
  assign SrcBE      = src_b_q ? imm_q : fwd_b;
  assign WriteDataE = fwd_b;
  assign ALUctrlE   = alu_ctrl_q;
  assign RdE        = rd_q;
  assign RegWriteE  = reg_write_q & valid_q;
  assign MemReadE   = mem_read_q & valid_q;
  assign ValidE     = valid_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scoreboard bench for ex_operand_stage (either EX_FORWARD_EN build).
module tb_ex_operand_stage;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0, rst, StallE, FlushE, ValidD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, ALUResultM, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
  logic [3:0]  ALUctrlD;
  logic        ALUsrcAD, ALUsrcBD, RegWriteD, MemReadD, RegWriteM, RegWriteW;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [3:0]  ALUctrlE;
  logic [4:0]  RdE;
  logic        RegWriteE, MemReadE, ValidE, LoadUseStall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    bit          data;
    logic [31:0] a, b, wd;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw, mr, v, lus;
  } exp_t;
  exp_t sb[$];

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUctrlD(ALUctrlD),
    .ALUsrcAD(ALUsrcAD), .ALUsrcBD(ALUsrcBD), .RegWriteD(RegWriteD), .MemReadD(MemReadD),
    .RdM(RdM), .RegWriteM(RegWriteM), .ALUResultM(ALUResultM),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUctrlE(ALUctrlE), .WriteDataE(WriteDataE),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .ValidE(ValidE),
    .LoadUseStall(LoadUseStall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit data, input logic [31:0] a, b, wd,
                      input logic [3:0] ctrl, input logic [4:0] rd,
                      input logic rw, mr, v, lus);
    exp_t e;
    e.tag = tag; e.data = data; e.a = a; e.b = b; e.wd = wd; e.ctrl = ctrl;
    e.rd = rd; e.rw = rw; e.mr = mr; e.v = v; e.lus = lus;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard empty observed=none expected=entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".valid"}, 32'(ValidE), 32'(e.v));
    cmp({e.tag, ".regwrite"}, 32'(RegWriteE), 32'(e.rw));
    cmp({e.tag, ".memread"}, 32'(MemReadE), 32'(e.mr));
    cmp({e.tag, ".rd"}, 32'(RdE), 32'(e.rd));
    cmp({e.tag, ".aluctrl"}, 32'(ALUctrlE), 32'(e.ctrl));
    cmp({e.tag, ".loaduse"}, 32'(LoadUseStall), 32'(e.lus));
    if (e.data) begin
      cmp({e.tag, ".srca"}, SrcAE, e.a);
      cmp({e.tag, ".srcb"}, SrcBE, e.b);
      cmp({e.tag, ".wdata"}, WriteDataE, e.wd);
    end
  endtask

  task automatic drive_d(input logic v, input logic [4:0] rs1, rs2, rd,
                         input logic [31:0] rd1, rd2, pc, imm, input logic [3:0] ctrl,
                         input logic sa, sbs, rw, mr);
    ValidD = v; Rs1D = rs1; Rs2D = rs2; RdD = rd; RD1D = rd1; RD2D = rd2;
    PCD = pc; ImmExtD = imm; ALUctrlD = ctrl; ALUsrcAD = sa; ALUsrcBD = sbs;
    RegWriteD = rw; MemReadD = mr;
  endtask

  task automatic set_mw(input logic rwm, input logic [4:0] rdm, input logic [31:0] alum,
                        input logic rww, input logic [4:0] rdw, input logic [31:0] resw);
    RegWriteM = rwm; RdM = rdm; ALUResultM = alum;
    RegWriteW = rww; RdW = rdw; ResultW = resw;
  endtask

  initial begin
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mw(0, 0, 0, 0, 0, 0);
    #2;
    push("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check();
    @(negedge clk) rst = 1'b0;

    // MEM forward onto rs1, then RdM = 0 disables it
    drive_d(1, 5, 6, 9, 32'h11, 32'h22, 32'h100, 32'h4, 4'h0, 0, 0, 1, 0);
    push("mem_fwd", 1, FWD ? 32'hAA : 32'h11, 32'h22, 32'h22, 0, 9, 1, 0, 1, 0);
    tick();
    drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mw(1, 5, 32'hAA, 0, 0, 0);
    #1 check();
    RdM = 5'd0;
    push("mem_rd0", 1, 32'h11, 32'h22, 32'h22, 0, 9, 1, 0, 1, 0);
    #1 check();

    // MEM over WB priority on rs2
    drive_d(1, 1, 7, 8, 32'h33, 32'h77, 32'h200, 32'h40, 4'h8, 0, 0, 1, 0);
    push("prio", 1, 32'h33, FWD ? 32'h1 : 32'h77, FWD ? 32'h1 : 32'h77, 4'h8, 8, 1, 0, 1, 0);
    tick();
    drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mw(1, 7, 32'h1, 1, 7, 32'h2);
    #1 check();
    RegWriteM = 1'b0;
    push("wb_only", 1, 32'h33, FWD ? 32'h2 : 32'h77, FWD ? 32'h2 : 32'h77, 4'h8, 8, 1, 0, 1, 0);
    #1 check();
    drive_d(1, 1, 7, 8, 32'h33, 32'h77, 32'h200, 32'h40, 4'h8, 0, 1, 1, 0);
    push("imm_b", 1, 32'h33, 32'h40, FWD ? 32'h1 : 32'h77, 4'h8, 8, 1, 0, 1, 0);
    tick();
    drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RegWriteM = 1'b1;
    #1 check();

    // load-use: load rd=3 in E, consumer with rs2=3 in D
    set_mw(0, 0, 0, 0, 0, 0);
    drive_d(1, 2, 4, 3, 32'h5, 32'h6, 32'h300, 32'h0, 4'h0, 0, 0, 1, 1);
    push("ld_use", 1, 32'h5, 32'h6, 32'h6, 0, 3, 1, 1, 1, 1);
    tick();
    drive_d(1, 1, 3, 10, 32'h50, 32'h60, 32'h304, 32'h0, 4'h0, 0, 0, 1, 0);
    #1 check();
    FlushE = 1'b1;
    push("ld_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check();
    FlushE = 1'b0;
    push("ld_wb_fwd", 1, 32'h50, FWD ? 32'hDEAD : 32'h60, FWD ? 32'hDEAD : 32'h60, 0, 10, 1, 0, 1, 0);
    tick();
    set_mw(0, 0, 0, 1, 3, 32'hDEAD);
    #1 check();

    // stall holds for two cycles, then stall+flush inserts a bubble
    StallE = 1'b1;
    drive_d(1, 0, 0, 12, 32'h99, 32'h98, 32'h400, 32'h8, 4'h3, 1, 1, 1, 1);
    push("stall1", 1, 32'h50, FWD ? 32'hDEAD : 32'h60, FWD ? 32'hDEAD : 32'h60, 0, 10, 1, 0, 1, 0);
    tick();
    check();
    push("stall2", 1, 32'h50, FWD ? 32'hDEAD : 32'h60, FWD ? 32'hDEAD : 32'h60, 0, 10, 1, 0, 1, 0);
    tick();
    check();
    FlushE = 1'b1;
    push("stall_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check();
    StallE = 1'b0; FlushE = 1'b0;

    // x0 is never forwarded
    drive_d(1, 0, 0, 1, 32'h0, 32'h0, 32'h500, 32'h0, 4'h0, 0, 0, 0, 0);
    push("x0_mem", 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tick();
    drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_mw(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    #1 check();
    set_mw(0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    push("x0_wb", 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    #1 check();

    // asynchronous reset mid-cycle clears a loaded E stage before any edge
    set_mw(0, 0, 0, 0, 0, 0);
    drive_d(1, 4, 6, 5, 32'h123, 32'h456, 32'h600, 32'h10, 4'h2, 0, 0, 1, 1);
    push("loaded", 1, 32'h123, 32'h456, 32'h456, 4'h2, 5, 1, 1, 1, 0);
    tick();
    drive_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check();
    #1 rst = 1'b1;
    push("async_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
